wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between three writers:
  - the core writeback path (output of the ALU/load/PC+4 result mux);
  - the multi-cycle multiply/divide unit (MDU);
  - the communication peripheral receive path (COM, UART/SPI RX data into rd).
- The core writeback has fixed priority.
- MDU and COM use valid/ready handshakes and are round-robin arbitrated between themselves.
- A starvation guard stalls the core for one cycle so a blocked secondary writer can retire.

---
 rtl/wb_port_arbiter.sv | 117 +++++++++++
 tb/tb_wb_port_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the core writeback has fixed priority, and MDU/COM
// share the leftover slots round-robin, with a one-cycle core stall to relieve starvation.
module wb_port_arbiter #(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            core_we,
   input  logic [4:0]      core_rd,
   input  logic [XLEN-1:0] core_wd,
   input  logic            mdu_valid,
   input  logic [4:0]      mdu_rd,
   input  logic [XLEN-1:0] mdu_wd,
   output logic            mdu_ready,
   input  logic            com_valid,
   input  logic [4:0]      com_rd,
   input  logic [XLEN-1:0] com_wd,
   output logic            com_ready,
   output logic            rf_we,
   output logic [4:0]      rf_rd,
   output logic [XLEN-1:0] rf_wd,
   output logic            core_stall
);

   localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);
   localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

   typedef enum logic {
      RR_MDU = 1'b0,
      RR_COM = 1'b1
   } rr_t;

   rr_t        rr_ptr, rr_next;
   logic [3:0] mdu_wait, mdu_wait_next;
   logic [3:0] com_wait, com_wait_next;
   logic       core_stall_next;

   logic eff_core;
   logic mdu_elig, com_elig;
   logic mdu_discard, com_discard;
   logic grant_mdu, grant_com;
   logic mdu_blocked, com_blocked;

   assign eff_core    = core_we & (core_rd != 5'd0) & ~core_stall;
   assign mdu_elig    = mdu_valid & (mdu_rd != 5'd0);
   assign com_elig    = com_valid & (com_rd != 5'd0);
   assign mdu_discard = mdu_valid & (mdu_rd == 5'd0);
   assign com_discard = com_valid & (com_rd == 5'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr     <= RR_MDU;
         mdu_wait   <= '0;
         com_wait   <= '0;
         core_stall <= 1'b0;
      end else begin
         rr_ptr     <= rr_next;
         mdu_wait   <= mdu_wait_next;
         com_wait   <= com_wait_next;
         core_stall <= core_stall_next;
      end
   end

   // Grant and write-port mux; reset forces every output and grant low.
   always_comb begin
      rf_we     = 1'b0;
      rf_rd     = '0;
      rf_wd     = '0;
      grant_mdu = 1'b0;
      grant_com = 1'b0;
      if (!rst) begin
         if (eff_core) begin
            rf_we = 1'b1;
            rf_rd = core_rd;
            rf_wd = core_wd;
         end else if (mdu_elig && (!com_elig || rr_ptr == RR_MDU)) begin
            grant_mdu = 1'b1;
            rf_we     = 1'b1;
            rf_rd     = mdu_rd;
            rf_wd     = mdu_wd;
         end else if (com_elig) begin
            grant_com = 1'b1;
            rf_we     = 1'b1;
            rf_rd     = com_rd;
            rf_wd     = com_wd;
         end
      end
      mdu_ready = ~rst & (grant_mdu | mdu_discard);
      com_ready = ~rst & (grant_com | com_discard);
   end

   assign mdu_blocked = mdu_elig & ~mdu_ready;
   assign com_blocked = com_elig & ~com_ready;

   // Next-state: round-robin pointer, saturating wait counters, single-cycle stall.
   always_comb begin
      rr_next       = rr_ptr;
      mdu_wait_next = '0;
      com_wait_next = '0;
      if (grant_mdu) begin
         rr_next = RR_COM;
      end else if (grant_com) begin
         rr_next = RR_MDU;
      end
      if (mdu_blocked) begin
         mdu_wait_next = (mdu_wait >= LIMIT) ? LIMIT : mdu_wait + 4'd1;
      end
      if (com_blocked) begin
         com_wait_next = (com_wait >= LIMIT) ? LIMIT : com_wait + 4'd1;
      end
      core_stall_next = ~core_stall &
                        ((mdu_blocked & (mdu_wait == LIMIT_M1)) |
                         (com_blocked & (com_wait == LIMIT_M1)));
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: literal test-plan checks plus a per-cycle
// comparison against a rule-level model of the arbitration and starvation guard.
module tb_wb_port_arbiter;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        core_we;
   logic [4:0]  core_rd;
   logic [31:0] core_wd;
   logic        mdu_valid;
   logic [4:0]  mdu_rd;
   logic [31:0] mdu_wd;
   logic        mdu_ready;
   logic        com_valid;
   logic [4:0]  com_rd;
   logic [31:0] com_wd;
   logic        com_ready;
   logic        rf_we;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wd;
   logic        core_stall;

   int tests = 0;
   int fails = 0;

   wb_port_arbiter #(.XLEN(32), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .core_we(core_we), .core_rd(core_rd), .core_wd(core_wd),
      .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_wd(mdu_wd), .mdu_ready(mdu_ready),
      .com_valid(com_valid), .com_rd(com_rd), .com_wd(com_wd), .com_ready(com_ready),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd), .core_stall(core_stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: stall flag, round-robin preference (0 = MDU, 1 = COM), wait counts.
   int m_stall = 0;
   int m_rr    = 0;
   int m_mw    = 0;
   int m_cw    = 0;

   typedef struct packed {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] wd;
      logic        mr;
      logic        cr;
      logic        mg;
      logic        cg;
   } exp_t;

   function automatic exp_t model_eval();
      exp_t e;
      bit   me, ce;
      int   who;
      e   = '0;
      me  = mdu_valid && mdu_rd != 0;
      ce  = com_valid && com_rd != 0;
      who = -1;
      if (rst) return e;
      e.mr = mdu_valid && mdu_rd == 0;
      e.cr = com_valid && com_rd == 0;
      if (core_we && core_rd != 0 && m_stall == 0) begin
         e.we = 1'b1; e.rd = core_rd; e.wd = core_wd;
      end else begin
         if (me && ce) who = m_rr;
         else if (me)  who = 0;
         else if (ce)  who = 1;
         if (who == 0) begin
            e.we = 1'b1; e.rd = mdu_rd; e.wd = mdu_wd; e.mr = 1'b1; e.mg = 1'b1;
         end else if (who == 1) begin
            e.we = 1'b1; e.rd = com_rd; e.wd = com_wd; e.cr = 1'b1; e.cg = 1'b1;
         end
      end
      return e;
   endfunction

   always @(posedge clk) begin
      exp_t e;
      bit   mblk, cblk;
      int   nstall;
      e = model_eval();
      if (rst) begin
         m_stall = 0; m_rr = 0; m_mw = 0; m_cw = 0;
      end else begin
         mblk   = mdu_valid && mdu_rd != 0 && !e.mr;
         cblk   = com_valid && com_rd != 0 && !e.cr;
         nstall = (m_stall == 0 && ((mblk && m_mw == LIMIT - 1) ||
                                    (cblk && m_cw == LIMIT - 1))) ? 1 : 0;
         m_mw   = mblk ? ((m_mw + 1 > LIMIT) ? LIMIT : m_mw + 1) : 0;
         m_cw   = cblk ? ((m_cw + 1 > LIMIT) ? LIMIT : m_cw + 1) : 0;
         if (e.mg) m_rr = 1;
         else if (e.cg) m_rr = 0;
         m_stall = nstall;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      e = model_eval();
      chk("mdl_rf_we",  32'(rf_we),      32'(e.we));
      chk("mdl_rf_rd",  32'(rf_rd),      32'(e.rd));
      chk("mdl_rf_wd",  rf_wd,           e.wd);
      chk("mdl_mdu_rdy", 32'(mdu_ready), 32'(e.mr));
      chk("mdl_com_rdy", 32'(com_ready), 32'(e.cr));
      chk("mdl_stall",  32'(core_stall), 32'(m_stall));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic cw, input logic [4:0] cr, input logic [31:0] cd,
                        input logic mv, input logic [4:0] mr, input logic [31:0] md,
                        input logic sv, input logic [4:0] sr, input logic [31:0] sd);
      core_we = cw;   core_rd = cr; core_wd = cd;
      mdu_valid = mv; mdu_rd = mr;  mdu_wd = md;
      com_valid = sv; com_rd = sr;  com_wd = sd;
   endtask

   task automatic expect_out(input string name, input logic we, input logic [4:0] rd,
                             input logic [31:0] wd, input logic mr, input logic cr,
                             input logic st);
      @(negedge clk);
      chk({name, "_we"},    32'(rf_we),      32'(we));
      chk({name, "_rd"},    32'(rf_rd),      32'(rd));
      chk({name, "_wd"},    rf_wd,           wd);
      chk({name, "_mrdy"},  32'(mdu_ready),  32'(mr));
      chk({name, "_crdy"},  32'(com_ready),  32'(cr));
      chk({name, "_stall"}, 32'(core_stall), 32'(st));
   endtask

   initial begin
      logic ms;
      logic cs;
      rst = 1'b1;
      drive(1, 5'd5, 32'h4, 1, 5'd3, 32'h8, 1, 5'd7, 32'hC);
      @(negedge clk);
      chk("rst_rf_we", 32'(rf_we), 32'd0);
      chk("rst_mrdy",  32'(mdu_ready), 32'd0);
      chk("rst_crdy",  32'(com_ready), 32'd0);
      tick();
      rst = 1'b0;

      // Core-only write.
      drive(1, 5'd5, 32'h4, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      expect_out("core", 1, 5'd5, 32'h4, 0, 0, 0);

      // Both secondaries held, core idle: MDU first, then COM.
      tick();
      drive(0, 5'd0, 32'h0, 1, 5'd3, 32'h8, 1, 5'd7, 32'hC);
      expect_out("rr1", 1, 5'd3, 32'h8, 1, 0, 0);
      tick();
      drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd7, 32'hC);
      expect_out("rr2", 1, 5'd7, 32'hC, 0, 1, 0);

      // x0 discard alongside a core write, single and double.
      tick();
      drive(1, 5'd9, 32'h1, 1, 5'd0, 32'hFF, 0, 5'd0, 32'h0);
      expect_out("x0_mdu", 1, 5'd9, 32'h1, 1, 0, 0);
      tick();
      drive(1, 5'd9, 32'h1, 1, 5'd0, 32'hAA, 1, 5'd0, 32'hBB);
      expect_out("x0_both", 1, 5'd9, 32'h1, 1, 1, 0);

      // core_rd=0 frees the port for COM.
      tick();
      drive(1, 5'd0, 32'h55, 0, 5'd0, 32'h0, 1, 5'd4, 32'h20);
      expect_out("core_x0", 1, 5'd4, 32'h20, 0, 1, 0);

      // Starvation: four blocked cycles, stall in the fifth, core resumes in the sixth.
      tick();
      drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      for (int i = 1; i <= 4; i++) begin
         tick();
         drive(1, 5'd1, 32'h77, 1, 5'd2, 32'h10, 0, 5'd0, 32'h0);
         expect_out($sformatf("starve_blk%0d", i), 1, 5'd1, 32'h77, 0, 0, 0);
      end
      tick();
      expect_out("starve_stall", 1, 5'd2, 32'h10, 1, 0, 1);
      tick();
      drive(1, 5'd1, 32'h77, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      expect_out("starve_after", 1, 5'd1, 32'h77, 0, 0, 0);

      // Same again with reset landing in the stall cycle; counting restarts from zero.
      for (int i = 1; i <= 4; i++) begin
         tick();
         drive(1, 5'd1, 32'h77, 1, 5'd2, 32'h10, 0, 5'd0, 32'h0);
      end
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("rst_stall_we",   32'(rf_we),     32'd0);
      chk("rst_stall_mrdy", 32'(mdu_ready), 32'd0);
      chk("rst_stall_crdy", 32'(com_ready), 32'd0);
      tick();
      rst = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         expect_out($sformatf("rst_blk%0d", i), 1, 5'd1, 32'h77, 0, 0, 0);
         tick();
      end
      expect_out("rst_restall", 1, 5'd2, 32'h10, 1, 0, 1);

      // Both starve together: one stall, one grant; model tracks the remainder.
      tick();
      drive(1, 5'd1, 32'h77, 1, 5'd2, 32'h10, 1, 5'd6, 32'h30);
      repeat (7) tick();

      // Mixed traffic honouring the hold-while-not-ready rule.
      drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         ms = mdu_ready;
         cs = com_ready;
         tick();
         rst     = ($urandom_range(0, 29) == 0);
         core_we = ($urandom_range(0, 3) != 0);
         core_rd = 5'($urandom_range(0, 3));
         core_wd = $urandom;
         if (!(mdu_valid && !ms)) begin
            mdu_valid = ($urandom_range(0, 1) != 0);
            mdu_rd    = 5'($urandom_range(0, 4));
            mdu_wd    = $urandom;
         end
         if (!(com_valid && !cs)) begin
            com_valid = ($urandom_range(0, 1) != 0);
            com_rd    = 5'($urandom_range(0, 4));
            com_wd    = $urandom;
         end
      end
      rst = 1'b0;
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
